// File: rtl/q_frag_stage.sv
// rtl/q_frag_stage.sv - logic-cell output flop with sync set/reset, enable and serial config.
// Optional macro Q_FRAG_CFG_READBACK_EN adds CFG_SO and the readback snapshot on CFG_LD.
module q_frag_stage #(
    parameter int         INIT_CYCLES = 2,
    parameter logic [3:0] DEFAULT_CFG = 4'h0
) (
    input  logic QCK,
    input  logic QRN,
    input  logic CZI,
    input  logic QDI,
    input  logic QDS,
    input  logic QEN,
    input  logic QST,
    input  logic QRT,
    input  logic CFG_SE,
    input  logic CFG_SI,
    input  logic CFG_LD,
    output logic QZ,
    output logic READY
`ifdef Q_FRAG_CFG_READBACK_EN
    ,
    output logic CFG_SO
`endif
);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_RUN  = 2'd1,
        S_CFG  = 2'd2
    } state_t;

    localparam logic [7:0] LP_CNT_LAST = 8'(INIT_CYCLES - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cfg;
    logic [3:0] w_cfg_nxt;
    logic [3:0] r_sreg;
    logic [3:0] w_sreg_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic       r_q;
    logic       w_q_nxt;
    logic       r_ready;
    logic       w_d;

    // cfg bits: [0] INIT, [1] ZINV, [2] DS_FORCE, [3] EN_IGNORE
    assign w_d = (QDS | r_cfg[2]) ? QDI : CZI;

    always_ff @(posedge QCK or negedge QRN) begin
        if (!QRN) begin
            r_state <= S_INIT;
            r_cfg   <= DEFAULT_CFG;
            r_sreg  <= 4'b0000;
            r_cnt   <= 8'd0;
            r_q     <= DEFAULT_CFG[0];
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cfg   <= w_cfg_nxt;
            r_sreg  <= w_sreg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_q     <= w_q_nxt;
            r_ready <= (w_state_nxt == S_RUN);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cfg_nxt   = r_cfg;
        w_sreg_nxt  = r_sreg;
        w_cnt_nxt   = r_cnt;
        w_q_nxt     = r_q;

        // The shift register runs in every state; only its commit is state-dependent.
        if (CFG_SE) begin
            w_sreg_nxt = {CFG_SI, r_sreg[3:1]};
        end

        case (r_state)
            S_INIT: begin
                w_q_nxt = r_cfg[0];
                if (r_cnt == LP_CNT_LAST) begin
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = S_RUN;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_RUN: begin
                if (QRT) begin
                    w_q_nxt = 1'b0;
                end else if (QST) begin
                    w_q_nxt = 1'b1;
                end else if (QEN | r_cfg[3]) begin
                    w_q_nxt = w_d;
                end
                if (CFG_SE) begin
                    w_state_nxt = S_CFG;
                end else if (CFG_LD) begin
`ifdef Q_FRAG_CFG_READBACK_EN
                    w_sreg_nxt = r_cfg;
`else
                    w_cfg_nxt   = r_sreg;
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = S_INIT;
`endif
                end
            end
            S_CFG: begin
                if (!CFG_SE) begin
                    if (CFG_LD) begin
                        w_cfg_nxt   = r_sreg;
                        w_cnt_nxt   = 8'd0;
                        w_state_nxt = S_INIT;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            default: begin
                w_state_nxt = S_INIT;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    assign QZ    = r_q ^ r_cfg[1];
    assign READY = r_ready;

`ifdef Q_FRAG_CFG_READBACK_EN
    assign CFG_SO = r_sreg[0];
`endif

endmodule

// File: tb/tb_q_frag_stage.sv
// tb/tb_q_frag_stage.sv - directed scoreboard bench for q_frag_stage (DEFAULT_CFG=1, INIT_CYCLES=2).
module tb_q_frag_stage;

    logic QCK = 1'b0;
    logic QRN = 1'b0;
    logic CZI = 1'b0;
    logic QDI = 1'b0;
    logic QDS = 1'b0;
    logic QEN = 1'b0;
    logic QST = 1'b0;
    logic QRT = 1'b0;
    logic CFG_SE = 1'b0;
    logic CFG_SI = 1'b0;
    logic CFG_LD = 1'b0;
    logic QZ;
    logic READY;
`ifdef Q_FRAG_CFG_READBACK_EN
    logic CFG_SO;
`endif

    int checks = 0;
    int errors = 0;
    logic [1:0] sb_q[$];

    q_frag_stage #(
        .INIT_CYCLES(2),
        .DEFAULT_CFG(4'h1)
    ) dut (
        .QCK(QCK),
        .QRN(QRN),
        .CZI(CZI),
        .QDI(QDI),
        .QDS(QDS),
        .QEN(QEN),
        .QST(QST),
        .QRT(QRT),
        .CFG_SE(CFG_SE),
        .CFG_SI(CFG_SI),
        .CFG_LD(CFG_LD),
        .QZ(QZ),
        .READY(READY)
`ifdef Q_FRAG_CFG_READBACK_EN
        ,
        .CFG_SO(CFG_SO)
`endif
    );

    always #5 QCK = ~QCK;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag,
                       input logic czi, input logic qdi, input logic qds,
                       input logic qen, input logic qst, input logic qrt,
                       input logic se, input logic si, input logic ld,
                       input logic eqz, input logic erdy);
        logic [1:0] exp;
        CZI = czi; QDI = qdi; QDS = qds; QEN = qen; QST = qst; QRT = qrt;
        CFG_SE = se; CFG_SI = si; CFG_LD = ld;
        sb_q.push_back({eqz, erdy});
        @(posedge QCK);
        #1;
        exp = sb_q.pop_front();
        chk({tag, " qz"}, QZ, exp[1]);
        chk({tag, " ready"}, READY, exp[0]);
    endtask

    initial begin
        repeat (2) @(posedge QCK);
        #1;
        chk("reset qz", QZ, 1'b1);
        chk("reset ready", READY, 1'b0);
        QRN = 1'b1;

        //        tag          czi qdi qds qen qst qrt se si ld  qz rdy
        cyc("init1",           0,  0,  0,  1,  0,  1,  0, 0, 0,  1, 0);
        cyc("init2",           0,  0,  0,  1,  0,  1,  0, 0, 0,  1, 1);
        cyc("run czi0",        0,  0,  0,  1,  0,  0,  0, 0, 0,  0, 1);
        cyc("run czi1",        1,  0,  0,  1,  0,  0,  0, 0, 0,  1, 1);
        cyc("run czi1b",       1,  0,  0,  1,  0,  0,  0, 0, 0,  1, 1);
        cyc("run czi0b",       0,  0,  0,  1,  0,  0,  0, 0, 0,  0, 1);
        cyc("hold1",           1,  0,  0,  0,  0,  0,  0, 0, 0,  0, 1);
        cyc("hold2",           1,  0,  0,  0,  0,  0,  0, 0, 0,  0, 1);
        cyc("set only",        0,  0,  0,  0,  1,  0,  0, 0, 0,  1, 1);
        cyc("set+reset",       1,  0,  0,  1,  1,  1,  0, 0, 0,  0, 1);
        cyc("qdi path1",       0,  1,  1,  1,  0,  0,  0, 0, 0,  1, 1);
        cyc("qdi path0",       1,  0,  1,  1,  0,  0,  0, 0, 0,  0, 1);

        cyc("shift1",          0,  0,  0,  0,  0,  0,  1, 1, 0,  0, 0);
        cyc("shift2 ctl ign",  1,  0,  0,  1,  1,  0,  1, 1, 0,  0, 0);
        cyc("shift3",          1,  0,  0,  1,  0,  0,  1, 0, 0,  0, 0);
        cyc("shift4",          1,  0,  0,  1,  0,  0,  1, 0, 0,  0, 0);
        cyc("commit",          1,  0,  0,  1,  0,  0,  0, 0, 1,  1, 0);
        cyc("cinit1",          1,  0,  0,  1,  0,  0,  0, 0, 0,  0, 0);
        cyc("cinit2",          1,  0,  0,  1,  0,  0,  0, 0, 0,  0, 1);
        cyc("inv czi0",        0,  0,  0,  1,  0,  0,  0, 0, 0,  1, 1);
        cyc("inv czi1",        1,  0,  0,  1,  0,  0,  0, 0, 0,  0, 1);

        cyc("cfg enter",       1,  0,  0,  0,  0,  0,  1, 0, 0,  0, 0);
        cyc("cfg exit no ld",  1,  0,  0,  0,  0,  0,  0, 0, 0,  0, 1);
        cyc("kept inv czi0",   0,  0,  0,  1,  0,  0,  0, 0, 0,  1, 1);
        cyc("kept inv czi1",   1,  0,  0,  1,  0,  0,  0, 0, 0,  0, 1);

        cyc("rshift1",         1,  0,  0,  0,  0,  0,  1, 0, 0,  0, 0);
        cyc("rshift2",         1,  0,  0,  0,  0,  0,  1, 1, 0,  0, 0);
        CFG_SE = 1'b1; CFG_SI = 1'b1;
        #2;
        QRN = 1'b0;
        #1;
        chk("mid-shift reset qz", QZ, 1'b1);
        chk("mid-shift reset ready", READY, 1'b0);
        @(posedge QCK);
        #1;
        CFG_SE = 1'b0; CFG_SI = 1'b0; QEN = 1'b0; CZI = 1'b0;
        QRN = 1'b1;
        cyc("rinit1",          0,  0,  0,  0,  0,  0,  0, 0, 0,  1, 0);
        cyc("rinit2",          0,  0,  0,  0,  0,  0,  0, 0, 0,  1, 1);
        cyc("no partial czi0", 0,  0,  0,  1,  0,  0,  0, 0, 0,  0, 1);
        cyc("no partial czi1", 1,  0,  0,  1,  0,  0,  0, 0, 0,  1, 1);

`ifdef Q_FRAG_CFG_READBACK_EN
        cyc("a shift0",        1,  0,  0,  0,  0,  0,  1, 0, 0,  1, 0);
        cyc("a shift1",        1,  0,  0,  0,  0,  0,  1, 1, 0,  1, 0);
        cyc("a shift2",        1,  0,  0,  0,  0,  0,  1, 0, 0,  1, 0);
        cyc("a shift3",        1,  0,  0,  0,  0,  0,  1, 1, 0,  1, 0);
        cyc("a commit",        1,  0,  0,  0,  0,  0,  0, 0, 1,  0, 0);
        cyc("a init1",         1,  0,  0,  0,  0,  0,  0, 0, 0,  1, 0);
        cyc("a init2",         1,  0,  0,  0,  0,  0,  0, 0, 0,  1, 1);
        cyc("en ignore czi1",  1,  0,  0,  0,  0,  0,  0, 0, 0,  0, 1);
        cyc("en ignore czi0",  0,  0,  0,  0,  0,  0,  0, 0, 0,  1, 1);
        cyc("clr shift1",      0,  0,  0,  0,  0,  0,  1, 0, 0,  1, 0);
        cyc("clr shift2",      0,  0,  0,  0,  0,  0,  1, 0, 0,  1, 0);
        cyc("clr shift3",      0,  0,  0,  0,  0,  0,  1, 0, 0,  1, 0);
        cyc("clr shift4",      0,  0,  0,  0,  0,  0,  1, 0, 0,  1, 0);
        cyc("clr exit",        0,  0,  0,  0,  0,  0,  0, 0, 0,  1, 1);
        cyc("readback",        0,  0,  0,  0,  0,  0,  0, 0, 1,  1, 1);
        chk("so bit0", CFG_SO, 1'b0);
        cyc("rb shift1",       0,  0,  0,  0,  0,  0,  1, 0, 0,  1, 0);
        chk("so bit1", CFG_SO, 1'b1);
        cyc("rb shift2",       0,  0,  0,  0,  0,  0,  1, 0, 0,  1, 0);
        chk("so bit2", CFG_SO, 1'b0);
        cyc("rb shift3",       0,  0,  0,  0,  0,  0,  1, 0, 0,  1, 0);
        chk("so bit3", CFG_SO, 1'b1);
`else
        cyc("run ld commit",   1,  0,  0,  1,  0,  0,  0, 0, 1,  1, 0);
        cyc("zinit1",          1,  0,  0,  1,  0,  0,  0, 0, 0,  0, 0);
        cyc("zinit2",          1,  0,  0,  1,  0,  0,  0, 0, 0,  0, 1);
        cyc("zero cfg czi1",   1,  0,  0,  1,  0,  0,  0, 0, 0,  1, 1);
        cyc("zero cfg czi0",   0,  0,  0,  1,  0,  0,  0, 0, 0,  0, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
